// File: rtl/alu_shift_seq_if.sv
// Handshake and ALU control/status bundle between decode, the shift sequencer and the ALU datapath.
// master = decode/ALU side driving requests and ALU status; slave = the sequencer.
interface alu_shift_seq_if;
    logic       start;
    logic [2:0] opsel;
    logic [7:0] operand;
    logic       carry_in;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_shdbl;

    logic [7:0] ctl_op;
    logic       ctl_si;
    logic [1:0] ctl_sh;
    logic [1:0] ctl_oe;
    logic       ctl_la;
    logic       ctl_lb;
    logic       ctl_l;
    logic       ctl_h;
    logic       busy;
    logic       done;
    logic [7:0] res;
    logic       flag_z;
    logic       flag_n;
    logic       flag_h;
    logic       flag_c;

    modport master (
        output start, opsel, operand, carry_in, alu_result, alu_zero, alu_shdbl,
        input  ctl_op, ctl_si, ctl_sh, ctl_oe, ctl_la, ctl_lb, ctl_l, ctl_h,
        input  busy, done, res, flag_z, flag_n, flag_h, flag_c
    );

    modport slave (
        input  start, opsel, operand, carry_in, alu_result, alu_zero, alu_shdbl,
        output ctl_op, ctl_si, ctl_sh, ctl_oe, ctl_la, ctl_lb, ctl_l, ctl_h,
        output busy, done, res, flag_z, flag_n, flag_h, flag_c
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Sequences the ALU control lines for the CB-prefix shift/rotate ops: SETTLE idle cycles, SHIFT, WRITE, DONE.
// Latency start->done is SETTLE+3 cycles; start is only accepted in IDLE, so requests while busy are dropped.
module alu_shift_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    alu_shift_seq_if.slave bus
);

    localparam logic [2:0] OP_RLC  = 3'd0;
    localparam logic [2:0] OP_RRC  = 3'd1;
    localparam logic [2:0] OP_RL   = 3'd2;
    localparam logic [2:0] OP_RR   = 3'd3;
    localparam logic [2:0] OP_SLA  = 3'd4;
    localparam logic [2:0] OP_SRA  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_SRL  = 3'd7;

    localparam logic [1:0] SH_LEFT  = 2'd1;
    localparam logic [1:0] SH_RIGHT = 2'd2;
    localparam logic [1:0] SH_SWAP  = 2'd3;
    localparam logic [1:0] OE_SHIFT = 2'd1;
    localparam logic [1:0] OE_RES   = 2'd2;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] opsel_q;
    logic [7:0] operand_q;
    logic       cin_q;
    logic [7:0] res_q;
    logic       flag_z_q;
    logic       flag_c_q;
    logic       accept;

    logic [7:0] ctl_op;
    logic       ctl_si;
    logic [1:0] ctl_sh;
    logic [1:0] ctl_oe;
    logic       ctl_la;
    logic       ctl_lb;
    logic       ctl_l;
    logic       ctl_h;
    logic       busy;
    logic       done;

    function automatic logic [1:0] shift_sel(input logic [2:0] op);
        logic [1:0] sel;
        case (op)
            OP_RLC, OP_RL, OP_SLA:          sel = SH_LEFT;
            OP_RRC, OP_RR, OP_SRA, OP_SRL:  sel = SH_RIGHT;
            default:                        sel = SH_SWAP;
        endcase
        return sel;
    endfunction

    // Bit fed into the vacated end; rotates recirculate, RL/RR pull in the old carry.
    function automatic logic shift_in(input logic [2:0] op, input logic [7:0] a, input logic cin);
        logic si;
        case (op)
            OP_RLC:        si = a[7];
            OP_RRC:        si = a[0];
            OP_RL, OP_RR:  si = cin;
            OP_SRA:        si = a[7];
            default:       si = 1'b0;
        endcase
        return si;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opsel_q   <= '0;
            operand_q <= '0;
            cin_q     <= 1'b0;
            res_q     <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                opsel_q   <= bus.opsel;
                operand_q <= bus.operand;
                cin_q     <= bus.carry_in;
            end
            if (state_q == S_SHIFT) begin
                flag_c_q <= (opsel_q == OP_SWAP) ? 1'b0 : bus.alu_shdbl;
            end
            if (state_q == S_WRITE) begin
                res_q    <= bus.alu_result;
                flag_z_q <= bus.alu_zero;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        ctl_op  = '0;
        ctl_si  = 1'b0;
        ctl_sh  = '0;
        ctl_oe  = '0;
        ctl_la  = 1'b0;
        ctl_lb  = 1'b0;
        ctl_l   = 1'b0;
        ctl_h   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                ctl_op  = operand_q;
                ctl_sh  = shift_sel(opsel_q);
                ctl_si  = shift_in(opsel_q, operand_q, cin_q);
                ctl_oe  = OE_SHIFT;
                ctl_la  = 1'b1;
                ctl_lb  = 1'b1;
                ctl_l   = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                ctl_oe  = OE_RES;
                ctl_h   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ctl_op = ctl_op;
    assign bus.ctl_si = ctl_si;
    assign bus.ctl_sh = ctl_sh;
    assign bus.ctl_oe = ctl_oe;
    assign bus.ctl_la = ctl_la;
    assign bus.ctl_lb = ctl_lb;
    assign bus.ctl_l  = ctl_l;
    assign bus.ctl_h  = ctl_h;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.res    = res_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = 1'b0;
    assign bus.flag_h = 1'b0;
    assign bus.flag_c = flag_c_q;

endmodule
